store_buffer: RTL and testbench



---
 rtl/store_buf_pkg.sv | 22 ++
 rtl/store_buf_fifo.sv | 94 +++++++++
 rtl/store_buffer.sv | 167 ++++++++++++++++
 tb/tb_store_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared types for the write-through store buffer: entry layout and drain FSM states.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// sb_entry_t is fixed at SB_AW/SB_DW bits. The store_buffer AW/DW parameters
// default to these widths and must be kept equal to them.
package store_buf_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Circular entry store for the store buffer: DEPTH entries, head/tail pointers, occupancy count.
// Latency: a push is visible on o_count/o_valid/o_entries the cycle after the edge; o_head is combinational.
// Backpressure: pushes while full and pops while empty are dropped (and asserted against).
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_push_entry write i_push_entry at tail
//   i_pop                retire the head entry
//   o_head               entry at head
//   o_entries, o_valid   all storage slots and their per-slot valid bits (for the address matcher)
//   o_head_ptr           head slot index, so the matcher can order entries by age
//   o_count              occupancy, 0..DEPTH
module store_buf_fifo
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  sb_entry_t                      i_push_entry,
  input  logic                           i_pop,
  output sb_entry_t                      o_head,
  output sb_entry_t [DEPTH-1:0]          o_entries,
  output logic      [DEPTH-1:0]          o_valid,
  output logic      [$clog2(DEPTH)-1:0]  o_head_ptr,
  output logic      [$clog2(DEPTH):0]    o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] r_mem;
  logic      [DEPTH-1:0] r_valid;
  logic      [PW-1:0]    r_head;
  logic      [PW-1:0]    r_tail;
  logic      [CW-1:0]    r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic      [DEPTH-1:0] w_valid_nxt;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  // Head and tail can only coincide when the FIFO is full or empty, and in
  // either case one of push/pop is suppressed, so the two updates never collide.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop)  w_valid_nxt[r_head] = 1'b0;
    if (w_push) w_valid_nxt[r_tail] = 1'b1;
  end

  // DEPTH is a power of two, so pointer increments wrap modulo DEPTH by overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head     = r_mem[r_head];
  assign o_entries  = r_mem;
  assign o_valid    = r_valid;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;

  // The parent gates push with "not full" and pop with "busy", so neither
  // should ever be requested against the wrong occupancy.
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_push |-> !w_full);
  a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_pop |-> !w_empty);

endmodule

// File: rtl/store_buffer.sv
// Write-through store buffer: queues cache stores and replays them to data memory in FIFO order.
// Latency: push at edge N -> MemWriteThrough from edge N+1 at the earliest; one idle cycle between writes.
// Backpressure: StoreReady drops when all DEPTH entries are full; data memory paces the drain via WriteReady.
//
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   StoreValid/StoreAddr/StoreData  store from the cache, accepted when StoreReady=1
//   StoreReady                      buffer not full
//   MemWriteThrough/MemAddr/MemData write request for the head entry, held while BUSY
//   WriteReady                      data-memory write-done pulse
//   ReadMiss/MissAddr               pending cache read miss
//   MissHold                        miss must wait for a matching buffered store to drain
//   FwdHit/FwdData                  forwarding result (youngest matching store)
//   Empty, Count                    occupancy
//
// Build option: define STORE_BUF_FWD_EN to forward matching store data to read
// misses instead of holding them. Without it FwdHit/FwdData are tied to 0.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   StoreValid,
  input  logic [AW-1:0]          StoreAddr,
  input  logic [DW-1:0]          StoreData,
  output logic                   StoreReady,
  output logic                   MemWriteThrough,
  output logic [AW-1:0]          MemAddr,
  output logic [DW-1:0]          MemData,
  input  logic                   WriteReady,
  input  logic                   ReadMiss,
  input  logic [AW-1:0]          MissAddr,
  output logic                   MissHold,
  output logic                   FwdHit,
  output logic [DW-1:0]          FwdData,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t             w_push_entry;
  sb_entry_t             w_head;
  sb_entry_t [DEPTH-1:0] w_entries;
  logic      [DEPTH-1:0] w_valid;
  logic      [PW-1:0]    w_head_ptr;
  logic      [CW-1:0]    w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic      [DEPTH-1:0] w_match;
  logic                  w_any_match;

  sb_state_t             r_state;
  sb_state_t             w_state_nxt;

  assign w_push_entry.addr = StoreAddr;
  assign w_push_entry.data = StoreData;

  assign w_empty    = (w_count == '0);
  assign StoreReady = (w_count != CW'(DEPTH));
  assign w_push     = StoreValid && StoreReady;

  store_buf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (Clk),
    .i_rst_n      (Rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_head_ptr   (w_head_ptr),
    .o_count      (w_count)
  );

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= SB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A miss that does not hit a buffered store gets the memory port first, so
  // no new write is started under it. A hit miss (MissHold=1) needs the drain
  // to make progress, so it does not block. A write in flight always finishes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      SB_IDLE: begin
        if (!w_empty && !(ReadMiss && !MissHold)) begin
          w_state_nxt = SB_BUSY;
        end
      end
      SB_BUSY: begin
        if (WriteReady) begin
          w_pop       = 1'b1;
          w_state_nxt = SB_IDLE;
        end
      end
      default: w_state_nxt = SB_IDLE;
    endcase
  end

  // The head cannot move while BUSY (only the pop that ends BUSY moves it),
  // so the request stays stable without extra holding registers.
  assign MemWriteThrough = (r_state == SB_BUSY);
  assign MemAddr         = MemWriteThrough ? w_head.addr : '0;
  assign MemData         = MemWriteThrough ? w_head.data : '0;

  assign Empty = w_empty;
  assign Count = w_count;

  // ---------------------------------------------------------------------------
  // Address matcher
  // ---------------------------------------------------------------------------
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = w_valid[i] && (w_entries[i].addr == MissAddr);
    end
  end

  assign w_any_match = |w_match;

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] w_idx;
  logic [DW-1:0] w_young_data;

  // Walk from oldest (head) to youngest; the last match seen is the youngest.
  always_comb begin
    w_idx        = w_head_ptr;
    w_young_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head_ptr + PW'(k);
      if (w_match[w_idx]) begin
        w_young_data = w_entries[w_idx].data;
      end
    end
  end

  assign FwdHit   = ReadMiss && w_any_match;
  assign FwdData  = FwdHit ? w_young_data : '0;
  assign MissHold = 1'b0;
`else
  // Stored data and entry ordering are only needed for forwarding.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_head_ptr, w_entries};

  assign MissHold = ReadMiss && w_any_match;
  assign FwdHit   = 1'b0;
  assign FwdData  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of the buffer contents.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          StoreValid = 1'b0;
  logic [AW-1:0] StoreAddr = '0;
  logic [DW-1:0] StoreData = '0;
  logic          StoreReady;
  logic          MemWriteThrough;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemData;
  logic          WriteReady = 1'b0;
  logic          ReadMiss = 1'b0;
  logic [AW-1:0] MissAddr = '0;
  logic          MissHold;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic          Empty;
  logic [$clog2(DEPTH):0] Count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];       // model: buffered stores, oldest first
  bit   m_busy = 0;  // model: a write to memory is outstanding

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .StoreValid      (StoreValid),
    .StoreAddr       (StoreAddr),
    .StoreData       (StoreData),
    .StoreReady      (StoreReady),
    .MemWriteThrough (MemWriteThrough),
    .MemAddr         (MemAddr),
    .MemData         (MemData),
    .WriteReady      (WriteReady),
    .ReadMiss        (ReadMiss),
    .MissAddr        (MissAddr),
    .MissHold        (MissHold),
    .FwdHit          (FwdHit),
    .FwdData         (FwdData),
    .Empty           (Empty),
    .Count           (Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_match(input logic [AW-1:0] a);
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_youngest(input logic [AW-1:0] a);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == a) return mq[i].d;
    return '0;
  endfunction

  function automatic bit m_hold();
`ifdef STORE_BUF_FWD_EN
    return 1'b0;
`else
    return ReadMiss && m_match(MissAddr);
`endif
  endfunction

  // Model update at each clock edge: a write in flight finishes on WriteReady;
  // an idle buffer starts a write unless an unconflicted miss owns the port.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mq.delete();
      m_busy <= 1'b0;
    end else begin
      m_busy <= m_busy ? !WriteReady : ((mq.size() != 0) && !(ReadMiss && !m_hold()));
      if (StoreValid && mq.size() < DEPTH) mq.push_back('{StoreAddr, StoreData});
      if (m_busy && WriteReady) void'(mq.pop_front());
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (chk_en && Rst_n) begin
      chk("StoreReady", StoreReady, mq.size() != DEPTH);
      chk("Empty", Empty, mq.size() == 0);
      chk("Count", Count, mq.size());
      chk("MemWriteThrough", MemWriteThrough, m_busy);
      if (m_busy) begin
        chk("MemAddr", MemAddr, mq[0].a);
        chk("MemData", MemData, mq[0].d);
      end
`ifdef STORE_BUF_FWD_EN
      chk("MissHold", MissHold, 1'b0);
      chk("FwdHit", FwdHit, ReadMiss && m_match(MissAddr));
      if (ReadMiss && m_match(MissAddr)) chk("FwdData", FwdData, m_youngest(MissAddr));
`else
      chk("MissHold", MissHold, ReadMiss && m_match(MissAddr));
      chk("FwdHit", FwdHit, 1'b0);
      chk("FwdData", FwdData, 32'h0);
`endif
    end
  end

  // Inputs set here are the ones seen by the next rising edge.
  task automatic drv(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                     input logic wr, input logic rm, input logic [AW-1:0] ma);
    @(posedge Clk);
    #2;
    StoreValid = sv;
    StoreAddr  = sa;
    StoreData  = sd;
    WriteReady = wr;
    ReadMiss   = rm;
    MissAddr   = ma;
  endtask

  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_busy(input logic rm, input logic [AW-1:0] ma);
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, '0, '0, 1'b0, rm, ma);
      settle();
      if (MemWriteThrough) return;
    end
    chk("wait_busy_timeout", MemWriteThrough, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #2;
    Rst_n  = 1'b1;
    chk_en = 1'b1;
    settle();
    chk("rst_StoreReady", StoreReady, 1'b1);
    chk("rst_MWT", MemWriteThrough, 1'b0);
    chk("rst_MemAddr", MemAddr, 32'h0);
    chk("rst_MemData", MemData, 32'h0);
    chk("rst_Empty", Empty, 1'b1);
    chk("rst_Count", Count, 3'd0);
    chk("rst_MissHold", MissHold, 1'b0);
    chk("rst_FwdHit", FwdHit, 1'b0);

    // Single store through to memory.
    drv(1'b1, 32'h100, 32'hAAAA, 1'b0, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t1_Empty", Empty, 1'b0);
    chk("t1_Count", Count, 3'd1);
    chk("t1_MWT_not_yet", MemWriteThrough, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t1_MWT", MemWriteThrough, 1'b1);
    chk("t1_MemAddr", MemAddr, 32'h100);
    chk("t1_MemData", MemData, 32'hAAAA);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t1_Empty_after", Empty, 1'b1);
    chk("t1_MWT_after", MemWriteThrough, 1'b0);

    // Fill to DEPTH, push while full, then drain in order.
    for (int i = 0; i < 4; i++) drv(1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t2_Count_full", Count, 3'd4);
    chk("t2_StoreReady_full", StoreReady, 1'b0);
    drv(1'b1, 32'h500, 32'hDEAD, 1'b0, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t2_Count_5th_ignored", Count, 3'd4);
    chk("t2_head_addr", MemAddr, 32'h400);
    drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t2_Count_after_pop", Count, 3'd3);
    chk("t2_StoreReady_after_pop", StoreReady, 1'b1);
    for (int j = 1; j < 4; j++) begin
      wait_busy(1'b0, '0);
      chk("t2_drain_addr", MemAddr, 32'h400 + 32'(4 * j));
      chk("t2_drain_data", MemData, 32'h1000 + 32'(j));
      drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t2_Empty", Empty, 1'b1);

    // Simultaneous push and pop, then enough pairs to wrap the pointers.
    drv(1'b1, 32'h240, 32'h3000, 1'b0, 1'b0, '0);
    drv(1'b1, 32'h244, 32'h3001, 1'b0, 1'b0, '0);
    wait_busy(1'b0, '0);
    chk("t3_Count2", Count, 3'd2);
    chk("t3_head0", MemData, 32'h3000);
    drv(1'b1, 32'h248, 32'h3002, 1'b1, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t3_Count_pushpop", Count, 3'd2);
    for (int k = 3; k < 13; k++) begin
      wait_busy(1'b0, '0);
      chk("t3_wrap_order", MemData, 32'h3000 + 32'(k - 2));
      drv(1'b1, 32'h240 + 32'(4 * k), 32'h3000 + 32'(k), 1'b1, 1'b0, '0);
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t3_Count_after_pairs", Count, 3'd2);
    for (int k = 11; k < 13; k++) begin
      wait_busy(1'b0, '0);
      chk("t3_tail_order", MemData, 32'h3000 + 32'(k));
      drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t3_Empty", Empty, 1'b1);

    // Two stores to the same address against a read miss.
    drv(1'b1, 32'h200, 32'd5, 1'b0, 1'b1, 32'h200);
    drv(1'b1, 32'h200, 32'd9, 1'b0, 1'b1, 32'h200);
    drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h200);
    settle();
`ifdef STORE_BUF_FWD_EN
    chk("t4_FwdHit", FwdHit, 1'b1);
    chk("t4_FwdData", FwdData, 32'd9);
    chk("t4_MissHold", MissHold, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h200);
    settle();
    chk("t4_drain_blocked", MemWriteThrough, 1'b0);
    for (int j = 0; j < 2; j++) begin
      wait_busy(1'b0, '0);
      drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("t4_Count_drained", Count, 3'd0);
`else
    chk("t4_MissHold", MissHold, 1'b1);
    chk("t4_FwdHit", FwdHit, 1'b0);
    for (int j = 0; j < 2; j++) begin
      wait_busy(1'b1, 32'h200);
      chk("t4_hold_while_draining", MissHold, 1'b1);
      drv(1'b0, '0, '0, 1'b1, 1'b1, 32'h200);
    end
    drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h200);
    settle();
    chk("t4_hold_released", MissHold, 1'b0);
    chk("t4_Count_drained", Count, 3'd0);
`endif

    // Unconflicted miss blocks a drain start but not a write in flight.
    drv(1'b1, 32'h600, 32'h77, 1'b0, 1'b1, 32'h300);
    for (int j = 0; j < 3; j++) begin
      drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h300);
      settle();
      chk("t5_drain_blocked", MemWriteThrough, 1'b0);
    end
    wait_busy(1'b0, '0);
    chk("t5_MemAddr", MemAddr, 32'h600);
    drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h300);
    settle();
    chk("t5_busy_under_miss", MemWriteThrough, 1'b1);
    drv(1'b0, '0, '0, 1'b1, 1'b1, 32'h300);
    drv(1'b0, '0, '0, 1'b0, 1'b1, 32'h300);
    settle();
    chk("t5_Empty", Empty, 1'b1);
    chk("t5_MWT_done", MemWriteThrough, 1'b0);

    // Asynchronous reset in the middle of a write.
    drv(1'b1, 32'h700, 32'h1, 1'b0, 1'b0, '0);
    drv(1'b1, 32'h704, 32'h2, 1'b0, 1'b0, '0);
    wait_busy(1'b0, '0);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("t6_MWT", MemWriteThrough, 1'b0);
    chk("t6_Count", Count, 3'd0);
    chk("t6_Empty", Empty, 1'b1);
    chk("t6_StoreReady", StoreReady, 1'b1);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;

    // Randomized traffic on a small address set so misses often match.
    for (int c = 0; c < 3000; c++) begin
      drv(1'($urandom_range(0, 1)),
          32'h200 + 32'(4 * $urandom_range(0, 3)),
          $urandom,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 3) == 0),
          32'h200 + 32'(4 * $urandom_range(0, 3)));
    end
    for (int c = 0; c < 40; c++) drv(1'b0, '0, '0, 1'b1, 1'b0, '0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("rand_final_Empty", Empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
